// File: rtl/cpu_datapath.sv
// cpu_datapath
// Sixteen-bit datapath driven by a multi-cycle controller. It holds:
//   - an 8-entry register file
//   - SP, PC, MAR, MDR, ISR, Y and the {V,N,C,Z} flags
//   - a single internal bus feeding an ALU
// The ALU output (Z) is the write-back source for the registers.
// Every register updates on the rising edge of clk, using pre-edge values.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   funsel[2:0]         ALU function select
//   lsp/lpc/lmdr/lmar/  register load strobes
//   lisr/ly/wrr
//   rsel[2:0]           register-file index, used for tr reads and wrr writes
//   mrw                 memory write request (mem[MAR] <= MDR)
//   spmar/pcmar         MAR source select (SP wins, else PC, else Z)
//   mdrz/mdrm           MDR source select (memory wins, else Z, else hold)
//   tr/tsp/tpc/tmdr/    bus drivers, priority in that order
//   tisr
//   sflag               load flags from this cycle's ALU result
//   cc                  make lpc conditional on ISR[11:8]
//   isr, flags          instruction register and {V,N,C,Z} to the controller
//   mem_addr/mem_wdata  registered MAR / MDR
//   mem_we              memory write enable
//   mem_rdata           combinational read data at mem_addr
//   bus_conflict        sticky: more than one bus driver seen since reset
module cpu_datapath #(
  parameter logic [15:0] SP_INIT = 16'hFFFF,
  parameter logic [15:0] PC_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  funsel,
  input  logic        lsp,
  input  logic        lpc,
  input  logic        lmdr,
  input  logic        lmar,
  input  logic        lisr,
  input  logic        ly,
  input  logic        wrr,
  input  logic [2:0]  rsel,
  input  logic        mrw,
  input  logic        spmar,
  input  logic        pcmar,
  input  logic        mdrz,
  input  logic        mdrm,
  input  logic        tr,
  input  logic        tsp,
  input  logic        tpc,
  input  logic        tmdr,
  input  logic        tisr,
  input  logic        sflag,
  input  logic        cc,
  output logic [15:0] isr,
  output logic [3:0]  flags,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic        bus_conflict
);

  logic [15:0] rf_reg [0:7];
  logic [15:0] sp_reg, pc_reg, mar_reg, mdr_reg, isr_reg, y_reg;
  logic [3:0]  flags_reg;
  logic        conflict_reg;

  logic [15:0] bus;
  logic [4:0]  drv;
  logic        multi_drv;
  logic [16:0] res;
  logic [15:0] z;
  logic [15:0] y_sext;
  logic        c_out, v_out;
  logic        cond_true;

  // Bus: fixed priority mux. Two or more set bits in drv mark a conflict.
  assign drv       = {tr, tsp, tpc, tmdr, tisr};
  assign multi_drv = |(drv & (drv - 5'd1));

  always_comb begin
    bus = 16'h0000;
    if (tr)        bus = rf_reg[rsel];
    else if (tsp)  bus = sp_reg;
    else if (tpc)  bus = pc_reg;
    else if (tmdr) bus = mdr_reg;
    else if (tisr) bus = isr_reg;
  end

  assign y_sext = {{8{y_reg[7]}}, y_reg[7:0]};

  // ALU on a 17-bit result.
  // Additions take carry from bit 16. Subtractions report C as "no borrow",
  // so bit 16 is inverted for them.
  always_comb begin
    res   = 17'h0;
    c_out = 1'b0;
    v_out = 1'b0;
    case (funsel)
      3'b000: begin
        res   = {1'b0, y_reg} + {1'b0, bus};
        c_out = res[16];
        v_out = (y_reg[15] == bus[15]) && (res[15] != y_reg[15]);
      end
      3'b001: res = {1'b0, bus};
      3'b010: begin
        res   = {1'b0, bus} + {1'b0, y_sext};
        c_out = res[16];
        v_out = (bus[15] == y_sext[15]) && (res[15] != bus[15]);
      end
      3'b011: begin
        res   = {1'b0, y_reg} - {1'b0, bus};
        c_out = ~res[16];
        v_out = (y_reg[15] != bus[15]) && (res[15] != y_reg[15]);
      end
      3'b100: res = {1'b0, y_reg & bus};
      3'b101: res = {1'b0, y_reg | bus};
      3'b110: begin
        res   = {1'b0, bus} + 17'd1;
        c_out = res[16];
        v_out = ~bus[15] & res[15];
      end
      default: begin
        res   = {1'b0, bus} - 17'd1;
        c_out = ~res[16];
        v_out = bus[15] & ~res[15];
      end
    endcase
  end

  assign z = res[15:0];

  // Branch condition from ISR[11:8], tested against the current flags.
  // Flag bit order is {V,N,C,Z}.
  always_comb begin
    case (isr_reg[11:8])
      4'd0:    cond_true = 1'b1;
      4'd1:    cond_true = flags_reg[0];
      4'd2:    cond_true = ~flags_reg[0];
      4'd3:    cond_true = flags_reg[1];
      4'd4:    cond_true = ~flags_reg[1];
      4'd5:    cond_true = flags_reg[2];
      4'd6:    cond_true = ~flags_reg[2];
      4'd7:    cond_true = flags_reg[3];
      4'd8:    cond_true = ~flags_reg[3];
      default: cond_true = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf_reg[i] <= 16'h0000;
      sp_reg       <= SP_INIT;
      pc_reg       <= PC_INIT;
      mar_reg      <= 16'h0000;
      mdr_reg      <= 16'h0000;
      isr_reg      <= 16'h0000;
      y_reg        <= 16'h0000;
      flags_reg    <= 4'h0;
      conflict_reg <= 1'b0;
    end else begin
      if (wrr)                  rf_reg[rsel] <= z;
      if (lsp)                  sp_reg       <= z;
      if (lpc && (!cc || cond_true)) pc_reg  <= z;
      if (ly)                   y_reg        <= bus;
      if (lisr)                 isr_reg      <= mdr_reg;
      if (lmar) begin
        if (spmar)      mar_reg <= sp_reg;
        else if (pcmar) mar_reg <= pc_reg;
        else            mar_reg <= z;
      end
      // mem_rdata reflects pre-write contents, so a same-cycle mrw does not leak in.
      if (lmdr) begin
        if (mdrm)      mdr_reg <= mem_rdata;
        else if (mdrz) mdr_reg <= z;
      end
      if (sflag)     flags_reg    <= {v_out, z[15], c_out, (z == 16'h0000)};
      if (multi_drv) conflict_reg <= 1'b1;
    end
  end

  assign isr          = isr_reg;
  assign flags        = flags_reg;
  assign mem_addr     = mar_reg;
  assign mem_wdata    = mdr_reg;
  // Suppressed during reset so a reset mid-instruction never commits a write.
  assign mem_we       = mrw & ~reset;
  assign bus_conflict = conflict_reg;

endmodule

// File: doc/cpu_datapath.md
# cpu_datapath

Sixteen-bit datapath driven by the multi-cycle `controller`. It holds the register file, SP, PC, MAR, MDR, ISR, Y and flags, plus a single internal bus and an ALU. It connects to a synchronous-write, combinational-read memory. Control strobes change on the falling edge; every datapath register updates on the rising edge, so strobes are stable for half a cycle before use.

## Interface
- `SP_INIT`, 16'hFFFF, SP reset value
- `PC_INIT`, 16'h0000, PC reset value
- `clk  in  1  rising-edge clock`
- `reset  in  1  reset, synchronous, active-high`
- `funsel  in  3  ALU function select`
- `lsp, lpc, lmdr, lmar, lisr, ly, wrr  in  1 each  register load strobes`
- `rsel  in  3  register-file index for read (`tr`) and write (`wrr`)`
- `mrw  in  1  memory write: mem[MAR] <= MDR`
- `spmar, pcmar  in  1 each  MAR source SP / PC (else Z)`
- `mdrz, mdrm  in  1 each  MDR source Z / memory`
- `tr, tsp, tpc, tmdr, tisr  in  1 each  bus drivers`
- `sflag  in  1  load flags from the current ALU result`
- `cc  in  1  make `lpc` conditional on ISR[11:8]`
- `isr  out  16  instruction register, to the controller`
- `flags  out  4  {V,N,C,Z}`
- `mem_addr  out  16  = MAR`
- `mem_wdata  out  16  = MDR`
- `mem_we  out  1  = mrw`
- `mem_rdata  in  16  combinational read data at mem_addr`
- `bus_conflict  out  1  sticky: more than one bus driver asserted in a cycle`

## Operation
- Bus: with a single driver, BUS = R[rsel] (`tr`), SP, PC, MDR, or ISR. With no driver, BUS = 0. With more than one driver, priority is tr > tsp > tpc > tmdr > tisr and `bus_conflict` is set; it stays set until reset.
- ALU computes Z combinationally from Y and BUS. Carry and overflow are taken from the 17-bit result.
  - 000: Y+BUS
  - 001: BUS (pass)
  - 010: BUS + sext(Y[7:0]) (branch target)
  - 011: Y−BUS (C = no borrow)
  - 100: Y&BUS
  - 101: Y|BUS
  - 110: BUS+1
  - 111: BUS−1
  - For the logic functions and pass, C and V are 0.
- Loads:
  - `wrr`: R[rsel] <= Z
  - `lsp`: SP <= Z
  - `lpc`: PC <= Z, gated by condition when `cc` = 1
  - `ly`: Y <= BUS
  - `lisr`: ISR <= MDR
  - `lmar`: MAR <= SP if spmar, else PC if pcmar, else Z; spmar wins over pcmar
  - `lmdr`: MDR <= mem_rdata if mdrm, else Z if mdrz, else hold; mdrm wins over mdrz
- `sflag`: flags <= {V,N,C,Z} of this cycle's ALU result. Z = (result == 0), N = result[15].
- Condition ISR[11:8]:
  - 0 always
  - 1 Z; 2 !Z
  - 3 C; 4 !C
  - 5 N; 6 !N
  - 7 V; 8 !V
  - 9–15 never
  - A false condition leaves PC unchanged.
- Every load uses the values as they stand before the clock edge. Example: `lisr` and `lmdr` in the same cycle load ISR with the old MDR.
- Memory writes happen externally when mem_we=1 at the rising edge. The same-cycle `lmdr` with mdrm reads the pre-write memory contents.

## Timing
- On the rising edge with reset=1, outputs take these values:
  - PC = PC_INIT, SP = SP_INIT
  - R0–R7, MAR, MDR, ISR, Y = 0
  - flags = 0, bus_conflict = 0
  - All other strobes are ignored during reset.
- Reset mid-instruction discards all state with no partial writes. The controller restarts fetch from state 0.
- Latency: a load strobe sampled at rising edge N is visible on outputs after edge N.
- mem_addr and mem_wdata are registered (MAR/MDR). mem_we is combinational from `mrw`.
- Register read and write of the same rsel in one cycle returns the old value on the bus; the new value is written at the edge.
- SP and PC wrap modulo 2^16: SP 0x0000 − 1 = 0xFFFF, PC 0xFFFF + 1 = 0x0000. There is no trap.

## Test plan
- Reset then fetch: mem[0]=16'h9A05. Apply lmar+pcmar; then lmdr+mdrm; then lisr, plus tpc+lpc with funsel=110. Expect MAR=0, MDR=16'h9A05, ISR=16'h9A05, PC=1.
- ALU/flags: Y=16'h7FFF, R3=1. Apply tr, rsel=3, funsel=000, wrr, sflag. Expect R3=16'h8000 and flags V=1, N=1, C=0, Z=0. Repeat with funsel=011 and Y=1, R3=1: expect Z=1, C=1.
- Push: SP=SP_INIT. Apply tsp+lsp with funsel=111; then lmar+spmar; then tr with funsel=001 plus lmdr+mdrz; then mrw. Expect SP=16'hFFFE and mem[16'hFFFE]=R[rsel].
- Conditional branch: PC=16'h0010, ISR=16'h9_1_FC (cond 1, offset −4), Z flag=0. Apply tisr+ly; then tpc+lpc+cc with funsel=010. Expect PC unchanged at 16'h0010. Set Z=1 and repeat: expect PC=16'h000C.
- Bus conflict: assert tr and tpc together with funsel=001 and wrr. Expect BUS=R[rsel] and bus_conflict=1, held through later clean cycles until reset.
- Mid-operation reset: after a pending lmar/lmdr sequence, assert reset for one cycle alongside lpc. Expect PC=PC_INIT, SP=SP_INIT, and all other registers 0.
